// File: rtl/counter_driver.sv
// counter_driver: converts absolute target positions into enable/updown step
// pulses for an up/down counter, taking the shortest modular path.
// Optional abort input is compiled in when COUNTER_DRIVER_ABORT_EN is defined.
module counter_driver #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned GAP   = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tgt_valid,
   output logic             tgt_ready,
   input  logic [WIDTH-1:0] tgt_value,
`ifdef COUNTER_DRIVER_ABORT_EN
   input  logic             abort,
`endif
   output logic             enable,
   output logic             updown,
   output logic [WIDTH-1:0] pos,
   output logic             busy,
   output logic             done
);

   localparam int unsigned GW = (GAP > 1) ? $clog2(GAP + 1) : 1;
   localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_STEP = 2'd1,
      S_GAP  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] remaining, rem_nx;
   logic [GW-1:0]    gap_cnt, gap_nx;
   logic [WIDTH-1:0] pos_nx;
   logic             dir_nx;
   logic [WIDTH-1:0] diff_c;
   logic             up_c;
   logic             abort_c;

`ifdef COUNTER_DRIVER_ABORT_EN
   assign abort_c = abort;
`else
   assign abort_c = 1'b0;
`endif

   // Modular distance to the target; the exact half-way tie resolves up.
   assign diff_c = tgt_value - pos;
   assign up_c   = (diff_c <= HALF);

   // Next-state, step bookkeeping and shadow position update.
   always_comb begin
      state_nx = state;
      rem_nx   = remaining;
      gap_nx   = gap_cnt;
      pos_nx   = pos;
      dir_nx   = updown;
      case (state)
         S_IDLE: begin
            if (tgt_valid) begin
               if (diff_c == '0) begin
                  state_nx = S_DONE;
               end else begin
                  state_nx = S_STEP;
                  dir_nx   = up_c;
                  rem_nx   = up_c ? diff_c : (~diff_c + WIDTH'(1));
               end
            end
         end
         S_STEP: begin
            pos_nx = updown ? (pos + WIDTH'(1)) : (pos - WIDTH'(1));
            rem_nx = remaining - WIDTH'(1);
            if ((remaining == WIDTH'(1)) || abort_c) begin
               state_nx = S_DONE;
            end else if (GAP > 0) begin
               state_nx = S_GAP;
               gap_nx   = GW'(GAP);
            end
         end
         S_GAP: begin
            gap_nx = gap_cnt - GW'(1);
            if (abort_c) begin
               state_nx = S_DONE;
            end else if (gap_cnt == GW'(1)) begin
               state_nx = S_STEP;
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; outputs registered from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         remaining <= '0;
         gap_cnt   <= '0;
         pos       <= '0;
         updown    <= 1'b0;
         enable    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         tgt_ready <= 1'b1;
      end else begin
         state     <= state_nx;
         remaining <= rem_nx;
         gap_cnt   <= gap_nx;
         pos       <= pos_nx;
         updown    <= dir_nx;
         enable    <= (state_nx == S_STEP);
         busy      <= (state_nx == S_STEP) || (state_nx == S_GAP);
         done      <= (state_nx == S_DONE);
         tgt_ready <= (state_nx == S_IDLE);
      end
   end

endmodule
